// File: rtl/McoiDiagPkg.sv
// McoiDiagPkg: shared frame layout, FSM states and checksum
// for the McoiXu5Diagnostics RS485 framer.
package McoiDiagPkg;

   localparam logic [7:0] DIAG_SYNC_BYTE   = 8'hA5;
   localparam int         DIAG_FRAME_BYTES = 15;

   typedef logic [DIAG_FRAME_BYTES-1:0][7:0] diag_frame_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LEAD,
      ST_SHIFT,
      ST_GUARD
   } diag_state_t;

   // XOR of every payload byte, sync and checksum slot excluded
   function automatic logic [7:0] diag_checksum(input diag_frame_t f);
      logic [7:0] x;
      x = '0;
      for (int i = 1; i < DIAG_FRAME_BYTES - 1; i++) begin
         x ^= f[i];
      end
      return x;
   endfunction

endpackage

// File: rtl/mcoi_uart_tx_byte.sv
// mcoi_uart_tx_byte: UART 8N1 byte serialiser with valid/ready load.
// Ready rises in the last stop-bit cycle so bytes chain gap-free.
module mcoi_uart_tx_byte #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_i,
   input  logic [7:0] data_i,
   output logic       ready_o,
   output logic       tx_o,
   output logic       done_o
);

   localparam int            TW       = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

   logic          active_q;
   logic          tx_q;
   logic [8:0]    sh_q;
   logic [3:0]    bit_q;
   logic [TW-1:0] tmr_q;

   // done marks the final cycle of the stop bit
   always_comb begin
      done_o  = active_q && (bit_q == 4'd9) && (tmr_q == BIT_LAST);
      ready_o = !active_q || done_o;
      tx_o    = tx_q;
   end

   // load on handshake, then walk start, 8 data (LSB first), stop
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         tx_q     <= 1'b1;
         sh_q     <= '0;
         bit_q    <= '0;
         tmr_q    <= '0;
      end else if (valid_i && ready_o) begin
         active_q <= 1'b1;
         tx_q     <= 1'b0;
         sh_q     <= {1'b1, data_i};
         bit_q    <= '0;
         tmr_q    <= '0;
      end else if (active_q) begin
         if (tmr_q == BIT_LAST) begin
            tmr_q <= '0;
            if (bit_q == 4'd9) begin
               active_q <= 1'b0;
               tx_q     <= 1'b1;
            end else begin
               bit_q <= bit_q + 4'd1;
               tx_q  <= sh_q[0];
               sh_q  <= {1'b1, sh_q[8:1]};
            end
         end else begin
            tmr_q <= tmr_q + TW'(1);
         end
      end
   end

endmodule

// File: rtl/mcoi_diag_rs485_framer.sv
// mcoi_diag_rs485_framer: snapshots diagnostics into a 15-byte frame
// and sends it over RS485 periodically or on request.
module mcoi_diag_rs485_framer #(
   parameter int CLKS_PER_BIT  = 868,
   parameter int PERIOD_CYCLES = 100000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] temp_i,
   input  logic [15:0] power_i,
   input  logic [3:0]  rev_i,
   input  logic [63:0] id_i,
   input  logic        send_i,
   output logic        tx_o,
   output logic        de_o,
   output logic        busy_o,
   output logic        frame_done_o
);

   import McoiDiagPkg::*;

   localparam int            TW       = $clog2(CLKS_PER_BIT);
   localparam int            PW       = $clog2(PERIOD_CYCLES);
   localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);
   localparam logic [3:0]    IDX_END  = 4'(DIAG_FRAME_BYTES);

   logic [PW-1:0] per_q, per_d;
   logic          tick, trig;
   diag_frame_t   body, snap_d, buf_q;
   diag_state_t   st_q;
   logic [TW-1:0] tmr_q;
   logic [3:0]    idx_q;
   logic          de_q, busy_q, done_q, pend_q;
   logic [7:0]    cur_byte;
   logic          u_valid, u_ready, u_done, u_tx;

   // free-running period counter, tick on the wrap cycle
   always_comb begin
      tick  = (per_q == PER_LAST);
      per_d = tick ? '0 : per_q + PW'(1);
      trig  = tick || send_i;
   end

   // period counter state
   always_ff @(posedge clk) begin
      if (rst) per_q <= '0;
      else     per_q <= per_d;
   end

   // assemble the frame image from the live inputs
   always_comb begin
      body    = '0;
      body[0] = DIAG_SYNC_BYTE;
      body[1] = {4'h0, rev_i};
      body[2] = temp_i[15:8];
      body[3] = temp_i[7:0];
      body[4] = power_i[15:8];
      body[5] = power_i[7:0];
      for (int i = 0; i < 8; i++) begin
         body[6+i] = id_i[63-8*i -: 8];
      end
      snap_d     = body;
      snap_d[14] = diag_checksum(body);
   end

   // next byte to hand to the serialiser
   always_comb begin
      cur_byte = 8'hFF;
      for (int i = 0; i < DIAG_FRAME_BYTES; i++) begin
         if (idx_q == 4'(i)) cur_byte = buf_q[i];
      end
      u_valid = ((st_q == ST_LEAD) && (tmr_q == BIT_LAST))
             || ((st_q == ST_SHIFT) && (idx_q != IDX_END));
   end

   mcoi_uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .clk    (clk),
      .rst    (rst),
      .valid_i(u_valid),
      .data_i (cur_byte),
      .ready_o(u_ready),
      .tx_o   (u_tx),
      .done_o (u_done)
   );

   // frame sequencer: idle, lead-in, bytes, guard; 1-deep pending
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= ST_IDLE;
         tmr_q  <= '0;
         idx_q  <= '0;
         de_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pend_q <= 1'b0;
         buf_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (trig && (st_q != ST_IDLE)) pend_q <= 1'b1;
         unique case (st_q)
            ST_IDLE: begin
               if (trig || pend_q) begin
                  buf_q  <= snap_d;
                  st_q   <= ST_LEAD;
                  de_q   <= 1'b1;
                  busy_q <= 1'b1;
                  pend_q <= 1'b0;
                  tmr_q  <= '0;
                  idx_q  <= '0;
               end
            end
            ST_LEAD: begin
               if (tmr_q == BIT_LAST) begin
                  tmr_q <= '0;
                  idx_q <= 4'd1;
                  st_q  <= ST_SHIFT;
               end else begin
                  tmr_q <= tmr_q + TW'(1);
               end
            end
            ST_SHIFT: begin
               if (u_valid && u_ready) idx_q <= idx_q + 4'd1;
               if ((idx_q == IDX_END) && u_done) begin
                  st_q  <= ST_GUARD;
                  tmr_q <= '0;
               end
            end
            ST_GUARD: begin
               if (tmr_q == BIT_LAST) begin
                  st_q   <= ST_IDLE;
                  de_q   <= 1'b0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  tmr_q  <= '0;
               end else begin
                  tmr_q <= tmr_q + TW'(1);
               end
            end
         endcase
      end
   end

   assign tx_o         = u_tx;
   assign de_o         = de_q;
   assign busy_o       = busy_q;
   assign frame_done_o = done_q;

endmodule

// File: tb/tb_mcoi_diag_rs485_framer.sv
// tb_mcoi_diag_rs485_framer: scoreboard bench, UART decoder on tx_o,
// frame timing and trigger/pending/reset behaviour.
module tb_mcoi_diag_rs485_framer;

   localparam int CPB = 4;
   localparam int PER = 2000;
   localparam int DE_LEN = 152 * CPB;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] temp_i, power_i;
   logic [3:0]  rev_i;
   logic [63:0] id_i;
   logic        send_i;
   logic        tx_o, de_o, busy_o, frame_done_o;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   logic [7:0] sb[$];
   logic [7:0] T2_BYTES [15] = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h56,
                                 8'h78, 8'h01, 8'h23, 8'h45, 8'h67,
                                 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h0B};

   mcoi_diag_rs485_framer #(
      .CLKS_PER_BIT (CPB),
      .PERIOD_CYCLES(PER)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .temp_i      (temp_i),
      .power_i     (power_i),
      .rev_i       (rev_i),
      .id_i        (id_i),
      .send_i      (send_i),
      .tx_o        (tx_o),
      .de_o        (de_o),
      .busy_o      (busy_o),
      .frame_done_o(frame_done_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_frame(input logic [15:0] t, input logic [15:0] p,
                             input logic [3:0] rv, input logic [63:0] id);
      logic [7:0] f [15];
      logic [7:0] x;
      f[0] = 8'hA5;
      f[1] = {4'h0, rv};
      f[2] = t[15:8];
      f[3] = t[7:0];
      f[4] = p[15:8];
      f[5] = p[7:0];
      for (int i = 0; i < 8; i++) f[6+i] = id[63-8*i -: 8];
      x = '0;
      for (int i = 1; i < 14; i++) x ^= f[i];
      f[14] = x;
      for (int i = 0; i < 15; i++) sb.push_back(f[i]);
   endtask

   task automatic set_in(input logic [15:0] t, input logic [15:0] p,
                         input logic [3:0] rv, input logic [63:0] id);
      temp_i = t; power_i = p; rev_i = rv; id_i = id;
   endtask

   task automatic to_cyc(input int t);
      while (cyc < t) @(negedge clk);
      #1;
   endtask

   task automatic wait_fd(input string tag);
      int k;
      k = 0;
      @(negedge clk);
      while (!frame_done_o && k < 2000) begin
         @(negedge clk);
         k++;
      end
      #1;
      chk(tag, frame_done_o, 1'b1);
   endtask

   // monitor state
   logic       de_prev = 1'b0;
   logic       tx_prev = 1'b1;
   int         de_rise_cyc = 0;
   int         fd_cyc = 0;
   int         n_frames = 0;
   int         n_fd = 0;
   bit         rx_act = 0;
   int         rx_cnt = 0;
   int         rx_nb = 0;
   logic [7:0] rx_byte = '0;
   logic [7:0] exp_b;

   always @(negedge clk) begin
      if (!rst) begin
         if (de_o && !de_prev) begin
            de_rise_cyc = cyc;
            n_frames++;
            rx_nb = 0;
         end
         if (!de_o && de_prev) begin
            chk("de_len", cyc - de_rise_cyc, DE_LEN);
            chk("fd_at_fall", frame_done_o, 1'b1);
         end
         if (frame_done_o) begin
            n_fd++;
            fd_cyc = cyc;
            chk("fd_only_at_fall", de_prev && !de_o, 1'b1);
         end
         chk("busy_eq_de", busy_o, de_o);
         if (de_o && de_prev && (tx_o !== tx_prev))
            chk("bit_edge", (cyc - de_rise_cyc) % CPB, 0);
      end
      if (rst || !de_o) begin
         rx_act = 0;
      end else begin
         if (!rx_act && !tx_o) begin
            rx_act = 1;
            rx_cnt = 0;
            if (rx_nb == 0) chk("lead_len", cyc - de_rise_cyc, CPB);
         end
         if (rx_act) begin
            if (rx_cnt == CPB/2) chk("start_bit", tx_o, 1'b0);
            for (int b = 0; b < 8; b++)
               if (rx_cnt == CPB/2 + CPB*(b+1)) rx_byte[b] = tx_o;
            if (rx_cnt == CPB/2 + CPB*9) begin
               chk("stop_bit", tx_o, 1'b1);
               chk("sb_nonempty", sb.size() != 0, 1'b1);
               if (sb.size() != 0) begin
                  exp_b = sb.pop_front();
                  chk($sformatf("byte%0d", rx_nb), rx_byte, exp_b);
               end
               rx_nb++;
            end
            if (rx_cnt == CPB*10 - 1) rx_act = 0;
            else rx_cnt++;
         end
      end
      de_prev = de_o;
      tx_prev = tx_o;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, r2, s, fd1;
      rst = 1'b1;
      send_i = 1'b0;
      set_in(16'hBEEF, 16'h0042, 4'hA, 64'hDEADBEEF_CAFEF00D);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", tx_o, 1'b1);
      chk("rst_de", de_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_fd", frame_done_o, 1'b0);
      rst = 1'b0;
      r = cyc;
      push_frame(temp_i, power_i, rev_i, id_i);

      // 1: first periodic frame
      for (int k = 0; k < 4; k++) begin
         to_cyc(r + 1 + k*600);
         chk("t1_idle_de", de_o, 1'b0);
         chk("t1_idle_tx", tx_o, 1'b1);
      end
      to_cyc(r + PER - 1);
      chk("t1_pre_tick_de", de_o, 1'b0);
      to_cyc(r + PER);
      chk("t1_de_rise", de_o, 1'b1);
      chk("t1_rise_cyc", de_rise_cyc - r, PER);
      wait_fd("t1_done");
      chk("t1_frames", n_frames, 1);
      chk("t1_fd_count", n_fd, 1);
      chk("t1_sb_empty", sb.size(), 0);

      // 2/3: send_i frame, inputs changed mid-frame
      @(posedge clk);
      #1;
      set_in(16'h1234, 16'h5678, 4'h3, 64'h0123456789ABCDEF);
      send_i = 1'b1;
      for (int i = 0; i < 15; i++) sb.push_back(T2_BYTES[i]);
      @(posedge clk);
      #1;
      send_i = 1'b0;
      s = cyc;
      @(negedge clk);
      #1;
      chk("t2_de_rise", de_o, 1'b1);
      chk("t2_rise_cyc", de_rise_cyc, s);
      repeat (9) @(posedge clk);
      #1;
      set_in(16'hFFFF, 16'h0000, 4'hF, 64'h0);
      wait_fd("t2_done");
      chk("t2_frames", n_frames, 2);
      chk("t2_sb_empty", sb.size(), 0);

      // 4: three sends during a tick frame give one extra frame
      push_frame(temp_i, power_i, rev_i, id_i);
      to_cyc(r + 2*PER - 1);
      chk("t4_idle", de_o, 1'b0);
      to_cyc(r + 2*PER);
      chk("t4_rise_cyc", de_rise_cyc - r, 2*PER);
      for (int k = 0; k < 3; k++) begin
         to_cyc(r + 2*PER + 100 + 200*k);
         send_i = 1'b1;
         @(posedge clk);
         #1;
         send_i = 1'b0;
      end
      to_cyc(r + 2*PER + 560);
      set_in(16'h8001, 16'h7FFE, 4'h5, 64'hA5A5_0F0F_F0F0_5A5A);
      push_frame(temp_i, power_i, rev_i, id_i);
      wait_fd("t4_done1");
      fd1 = fd_cyc;
      @(negedge clk);
      #1;
      chk("t4_extra_de", de_o, 1'b1);
      chk("t4_extra_rise", de_rise_cyc, fd1 + 1);
      wait_fd("t4_done2");
      to_cyc(r + 3*PER - 100);
      chk("t4_frames", n_frames, 4);
      chk("t4_idle_after", de_o, 1'b0);
      chk("t4_sb_empty", sb.size(), 0);

      // 5: reset at byte 7 bit 4 of the next tick frame
      push_frame(temp_i, power_i, rev_i, id_i);
      to_cyc(r + 3*PER + CPB + 7*10*CPB + 4*CPB + 1);
      chk("t5_in_frame", de_o, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("t5_tx", tx_o, 1'b1);
      chk("t5_de", de_o, 1'b0);
      chk("t5_busy", busy_o, 1'b0);
      chk("t5_fd", frame_done_o, 1'b0);
      chk("t5_sb_left", sb.size(), 8);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      r2 = cyc;
      set_in(16'h0F0F, 16'hC3C3, 4'h9, 64'h1122334455667788);
      push_frame(temp_i, power_i, rev_i, id_i);
      to_cyc(r2 + 1000);
      chk("t5_quiet_de", de_o, 1'b0);
      to_cyc(r2 + PER - 1);
      chk("t5_quiet_de2", de_o, 1'b0);
      chk("t5_frames", n_frames, 5);

      // tick and send_i together: one frame only
      send_i = 1'b1;
      @(posedge clk);
      #1;
      send_i = 1'b0;
      @(negedge clk);
      #1;
      chk("t5_de_rise", de_o, 1'b1);
      chk("t5_rise_cyc", de_rise_cyc - r2, PER);
      wait_fd("t5_done");
      to_cyc(fd_cyc + 50);
      chk("t5_no_extra", de_o, 1'b0);
      chk("t5_frames_end", n_frames, 6);
      chk("t5_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
